// File: rtl/flash_boot_loader_pkg.sv
// Shared types and constants for the boot-time flash-to-SRAM copy engine.
package flash_boot_loader_pkg;

  localparam int unsigned WORD_W      = 32;
  localparam int unsigned WORD_BYTES  = 4;

  typedef logic [WORD_W-1:0] word_t;
  typedef logic              bit_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR_WAIT,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_WAIT,
    ST_DONE,
    ST_ERR
  } boot_state_t;

  localparam word_t FLASH_ERASED_WORD = 32'hFFFF_FFFF;
  localparam word_t WORD_STRIDE       = word_t'(WORD_BYTES);

endpackage

// File: rtl/flash_boot_loader_slave_handshake.sv
// Single-cycle op pulse towards a stalling slave, with stall tracking,
// per-transaction timeout and completion/timeout strobes.
module flash_boot_loader_slave_handshake
  import flash_boot_loader_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic stall,
  output logic op,
  output logic done_c,
  output logic timeout_c
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  bit_t             waiting;
  bit_t             seen_stall;
  logic [CNT_W-1:0] cnt;

  // Only a stall observed in an earlier cycle makes a low stall mean "finished".
  assign done_c    = waiting && seen_stall && !stall;
  assign timeout_c = waiting && !done_c && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op         <= 1'b0;
      waiting    <= 1'b0;
      seen_stall <= 1'b0;
      cnt        <= '0;
    end else begin
      op <= req;
      if (req) begin
        waiting    <= 1'b1;
        seen_stall <= 1'b0;
        cnt        <= '0;
      end else if (done_c || timeout_c) begin
        waiting    <= 1'b0;
        seen_stall <= 1'b0;
      end else if (waiting) begin
        cnt <= cnt + CNT_W'(1);
        if (stall) begin
          seen_stall <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/flash_boot_loader.sv
// Boot copy engine: reads a length header and payload from flash, writes the
// payload to SRAM, keeps the CPU in reset until the copy ends.
module flash_boot_loader
  import flash_boot_loader_pkg::*;
#(
  parameter word_t       FLASH_BASE     = 32'h0000_0000,
  parameter word_t       SRAM_BASE      = 32'h8000_0000,
  parameter int unsigned MAX_WORDS      = 4096,
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter bit          AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [31:0] copied_words,
  output logic [31:0] checksum,
  output logic [31:0] flash_addr,
  output logic        flash_read_op,
  input  logic [31:0] flash_rdata,
  input  logic        flash_stall,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  output logic        sram_write_op,
  input  logic        sram_stall
);

  boot_state_t state, state_d;
  word_t       len, len_d;
  bit_t        first_cycle;
  bit_t        cpu_hold_d, busy_d, done_d, error_d;
  word_t       copied_words_d, checksum_d, flash_addr_d, sram_addr_d, sram_wdata_d;
  bit_t        flash_req_c, sram_req_c;
  bit_t        flash_done_c, flash_timeout_c, sram_done_c, sram_timeout_c;
  bit_t        finish_ok_c, finish_err_c;

  flash_boot_loader_slave_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_flash_hs (
    .clk       (clk),
    .rst       (rst),
    .req       (flash_req_c),
    .stall     (flash_stall),
    .op        (flash_read_op),
    .done_c    (flash_done_c),
    .timeout_c (flash_timeout_c)
  );

  flash_boot_loader_slave_handshake #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_sram_hs (
    .clk       (clk),
    .rst       (rst),
    .req       (sram_req_c),
    .stall     (sram_stall),
    .op        (sram_write_op),
    .done_c    (sram_done_c),
    .timeout_c (sram_timeout_c)
  );

  // Next-state and next-register logic.
  always_comb begin
    state_d        = state;
    len_d          = len;
    cpu_hold_d     = cpu_hold;
    busy_d         = busy;
    done_d         = done;
    error_d        = error;
    copied_words_d = copied_words;
    checksum_d     = checksum;
    flash_addr_d   = flash_addr;
    sram_addr_d    = sram_addr;
    sram_wdata_d   = sram_wdata;
    flash_req_c    = 1'b0;
    sram_req_c     = 1'b0;
    finish_ok_c    = 1'b0;
    finish_err_c   = 1'b0;

    case (state)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start || (state == ST_IDLE && AUTO_START && first_cycle)) begin
          copied_words_d = '0;
          checksum_d     = '0;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          error_d        = 1'b0;
          cpu_hold_d     = 1'b1;
          flash_addr_d   = FLASH_BASE;
          flash_req_c    = 1'b1;
          state_d        = ST_HDR_WAIT;
        end
      end
      ST_HDR_WAIT: begin
        if (flash_done_c) begin
          len_d = flash_rdata;
          if (flash_rdata == '0) begin
            finish_ok_c = 1'b1;
          end else if (flash_rdata == FLASH_ERASED_WORD ||
                       flash_rdata > word_t'(MAX_WORDS)) begin
            finish_err_c = 1'b1;
          end else begin
            flash_addr_d = FLASH_BASE + WORD_STRIDE;
            sram_addr_d  = SRAM_BASE;
            state_d      = ST_RD_REQ;
          end
        end else if (flash_timeout_c) begin
          finish_err_c = 1'b1;
        end
      end
      ST_RD_REQ: begin
        flash_req_c = 1'b1;
        state_d     = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (flash_done_c) begin
          sram_wdata_d = flash_rdata;
          checksum_d   = checksum ^ flash_rdata;
          state_d      = ST_WR_REQ;
        end else if (flash_timeout_c) begin
          finish_err_c = 1'b1;
        end
      end
      ST_WR_REQ: begin
        sram_req_c = 1'b1;
        state_d    = ST_WR_WAIT;
      end
      ST_WR_WAIT: begin
        if (sram_done_c) begin
          copied_words_d = copied_words + 32'd1;
          flash_addr_d   = flash_addr + WORD_STRIDE;
          sram_addr_d    = sram_addr + WORD_STRIDE;
          if (copied_words + 32'd1 == len) begin
            finish_ok_c = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else if (sram_timeout_c) begin
          finish_err_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (finish_ok_c) begin
      state_d    = ST_DONE;
      busy_d     = 1'b0;
      done_d     = 1'b1;
      cpu_hold_d = 1'b0;
    end else if (finish_err_c) begin
      state_d = ST_ERR;
      busy_d  = 1'b0;
      error_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      len          <= '0;
      first_cycle  <= 1'b1;
      cpu_hold     <= 1'b1;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      copied_words <= '0;
      checksum     <= '0;
      flash_addr   <= '0;
      sram_addr    <= '0;
      sram_wdata   <= '0;
    end else begin
      state        <= state_d;
      len          <= len_d;
      first_cycle  <= 1'b0;
      cpu_hold     <= cpu_hold_d;
      busy         <= busy_d;
      done         <= done_d;
      error        <= error_d;
      copied_words <= copied_words_d;
      checksum     <= checksum_d;
      flash_addr   <= flash_addr_d;
      sram_addr    <= sram_addr_d;
      sram_wdata   <= sram_wdata_d;
    end
  end

endmodule

// File: tb/tb_flash_boot_loader.sv
// Bench for flash_boot_loader: behavioural stalling flash/SRAM slaves and a
// scoreboard of expected SRAM writes.
module tb_flash_boot_loader;

  localparam logic [31:0] SRAM_BASE   = 32'h8000_0000;
  localparam int          MAX_WORDS   = 4096;
  localparam int          TIMEOUT     = 256;
  localparam int          STALL       = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        cpu_hold, busy, done, error;
  logic [31:0] copied_words, checksum;
  logic [31:0] flash_addr;
  logic        flash_read_op;
  logic [31:0] flash_rdata = '0;
  logic        flash_stall = 1'b0;
  logic [31:0] sram_addr, sram_wdata;
  logic        sram_write_op;
  logic        sram_stall = 1'b0;

  always #5 clk = ~clk;

  flash_boot_loader dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .cpu_hold      (cpu_hold),
    .busy          (busy),
    .done          (done),
    .error         (error),
    .copied_words  (copied_words),
    .checksum      (checksum),
    .flash_addr    (flash_addr),
    .flash_read_op (flash_read_op),
    .flash_rdata   (flash_rdata),
    .flash_stall   (flash_stall),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_write_op (sram_write_op),
    .sram_stall    (sram_stall)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [31:0] flash_mem [16];
  int          n_checks = 0;
  int          n_errors = 0;
  int          f_ops = 0;
  int          s_ops = 0;
  bit          flash_mute = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Flash slave: stall rises one cycle after the pulse, lasts STALL cycles.
  int          f_phase = 0;
  int          f_left = 0;
  logic [31:0] f_addr = '0;
  always @(negedge clk) begin
    if (rst) begin
      flash_stall = 1'b0;
      f_phase     = 0;
    end else if (flash_read_op) begin
      f_ops++;
      f_addr  = flash_addr;
      f_phase = flash_mute ? 0 : 1;
    end else if (f_phase == 1) begin
      flash_stall = 1'b1;
      f_left      = STALL - 1;
      f_phase     = 2;
    end else if (f_phase == 2) begin
      f_left--;
      if (f_left == 0) begin
        flash_stall = 1'b0;
        flash_rdata = flash_mem[f_addr[5:2]];
        f_phase     = 0;
      end
    end
  end

  // SRAM slave: same stall shape; each write is checked against the scoreboard.
  int s_phase = 0;
  int s_left = 0;
  always @(negedge clk) begin
    if (rst) begin
      sram_stall = 1'b0;
      s_phase    = 0;
    end else if (sram_write_op) begin
      wr_t w;
      s_ops++;
      s_phase = 1;
      check("sram_write_expected", 32'(exp_q.size() != 0), 32'd1);
      check("cpu_hold_during_write", 32'(cpu_hold), 32'd1);
      if (exp_q.size() != 0) begin
        w = exp_q.pop_front();
        check("sram_addr", sram_addr, w.addr);
        check("sram_wdata", sram_wdata, w.data);
      end
    end else if (s_phase == 1) begin
      sram_stall = 1'b1;
      s_left     = STALL - 1;
      s_phase    = 2;
    end else if (s_phase == 2) begin
      s_left--;
      if (s_left == 0) begin
        sram_stall = 1'b0;
        s_phase    = 0;
      end
    end
  end

  task automatic load_image(input logic [31:0] hdr, input logic [31:0] w0,
                            input logic [31:0] w1, input logic [31:0] w2, input int n_push);
    logic [31:0] words [3];
    words[0] = w0; words[1] = w1; words[2] = w2;
    flash_mem[0] = hdr;
    flash_mem[1] = w0;
    flash_mem[2] = w1;
    flash_mem[3] = w2;
    for (int i = 0; i < n_push; i++) begin
      wr_t w;
      w.addr = SRAM_BASE + 32'(4 * i);
      w.data = words[i];
      exp_q.push_back(w);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input string tag);
    int n = 0;
    while (!((done || error) && !busy) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_finished"}, 32'((done || error) && !busy), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_error"}, 32'(error), 32'd0);
    check({tag, "_copied"}, copied_words, 32'd0);
    check({tag, "_checksum"}, checksum, 32'd0);
    check({tag, "_flash_addr"}, flash_addr, 32'd0);
    check({tag, "_flash_op"}, 32'(flash_read_op), 32'd0);
    check({tag, "_sram_addr"}, sram_addr, 32'd0);
    check({tag, "_sram_wdata"}, sram_wdata, 32'd0);
    check({tag, "_sram_op"}, 32'(sram_write_op), 32'd0);
  endtask

  initial begin
    int f0, s0, n;
    for (int i = 0; i < 16; i++) flash_mem[i] = '0;

    // Power-on reset, then auto-started 3-word copy with an ignored start.
    load_image(32'd3, 32'h1111_1111, 32'h2222_2222, 32'h4444_4444, 3);
    #1 rst = 1'b1;
    #20;
    check_reset_values("por");
    f0 = f_ops;
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("busy_mid_copy", 32'(busy), 32'd1);
    pulse_start();
    wait_end("copy3");
    check("copy3_done", 32'(done), 32'd1);
    check("copy3_error", 32'(error), 32'd0);
    check("copy3_cpu_hold", 32'(cpu_hold), 32'd0);
    check("copy3_checksum", checksum, 32'h7777_7777);
    check("copy3_copied", copied_words, 32'd3);
    check("copy3_flash_reads", 32'(f_ops - f0), 32'd4);
    check("copy3_q_empty", 32'(exp_q.size()), 32'd0);

    // Re-copy from DONE: counters restart from zero.
    load_image(32'd2, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0, 2);
    pulse_start();
    check("recopy_done_cleared", 32'(done), 32'd0);
    check("recopy_cpu_hold", 32'(cpu_hold), 32'd1);
    check("recopy_busy", 32'(busy), 32'd1);
    check("recopy_checksum_clr", checksum, 32'd0);
    check("recopy_copied_clr", copied_words, 32'd0);
    wait_end("copy2");
    check("copy2_done", 32'(done), 32'd1);
    check("copy2_checksum", checksum, 32'h0FF0_0FF0);
    check("copy2_copied", copied_words, 32'd2);
    check("copy2_q_empty", 32'(exp_q.size()), 32'd0);

    // Zero-length header.
    load_image(32'd0, 32'h0, 32'h0, 32'h0, 0);
    s0 = s_ops;
    pulse_start();
    wait_end("hdr0");
    check("hdr0_done", 32'(done), 32'd1);
    check("hdr0_error", 32'(error), 32'd0);
    check("hdr0_cpu_hold", 32'(cpu_hold), 32'd0);
    check("hdr0_checksum", checksum, 32'd0);
    check("hdr0_copied", copied_words, 32'd0);
    check("hdr0_writes", 32'(s_ops - s0), 32'd0);

    // Erased header.
    load_image(32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 0);
    s0 = s_ops;
    pulse_start();
    wait_end("erased");
    check("erased_error", 32'(error), 32'd1);
    check("erased_done", 32'(done), 32'd0);
    check("erased_cpu_hold", 32'(cpu_hold), 32'd1);
    check("erased_writes", 32'(s_ops - s0), 32'd0);

    // Header one past the limit, retried from ERR.
    load_image(32'(MAX_WORDS + 1), 32'h0, 32'h0, 32'h0, 0);
    s0 = s_ops;
    pulse_start();
    check("retry_error_cleared", 32'(error), 32'd0);
    wait_end("toolong");
    check("toolong_error", 32'(error), 32'd1);
    check("toolong_cpu_hold", 32'(cpu_hold), 32'd1);
    check("toolong_writes", 32'(s_ops - s0), 32'd0);

    // Flash never stalls: timeout exactly TIMEOUT cycles after the header pulse.
    load_image(32'd3, 32'h0, 32'h0, 32'h0, 0);
    flash_mute = 1'b1;
    pulse_start();
    check("timeout_pulse", 32'(flash_read_op), 32'd1);
    n = 0;
    while (!error && n < 1000) begin
      @(negedge clk);
      n++;
    end
    flash_mute = 1'b0;
    check("timeout_cycles", 32'(n), 32'(TIMEOUT));
    check("timeout_cpu_hold", 32'(cpu_hold), 32'd1);
    check("timeout_busy", 32'(busy), 32'd0);

    // Reset during word 2's flash wait, then auto-restart from the header.
    load_image(32'd3, 32'hA5A5_A5A5, 32'h5A5A_0000, 32'h0000_FFFF, 3);
    f0 = f_ops;
    pulse_start();
    n = 0;
    while (f_ops - f0 < 3 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_reached_word2", 32'(f_ops - f0), 32'd3);
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    check_reset_values("midrst");
    repeat (2) @(negedge clk);
    load_image(32'd3, 32'hA5A5_A5A5, 32'h5A5A_0000, 32'h0000_FFFF, 3);
    rst = 1'b0;
    n = 0;
    while (!flash_read_op && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("restart_hdr_pulse", 32'(flash_read_op), 32'd1);
    check("restart_hdr_addr", flash_addr, 32'd0);
    wait_end("restart");
    check("restart_done", 32'(done), 32'd1);
    check("restart_checksum", checksum, 32'hFFFF_5A5A);
    check("restart_copied", copied_words, 32'd3);
    check("restart_q_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
